instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the tinyML accelerator's control path. It reads 64-bit instructions as 8 consecutive bytes from the byte-wide instruction memory and assembles each one little-endian. It presents the result to the instruction decoder/controller through a valid/ready handshake. It advances the program counter by 8 per accepted instruction and stops after a programmed instruction count.

## Interface
- ADDR_W, 24, byte-address width; matches the 24-bit instruction addr field.
- INSTR_W, 64, instruction width; fixed at 8 bytes.
- MEM_LAT, 1, instruction-memory read latency in cycles (≥1).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a program run; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first instruction; latched on start.
- num_instr  in  16  number of instructions to fetch; latched on start.
- abort  in  1  synchronous flush to IDLE.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rdata  in  8  read data, valid MEM_LAT cycles after mem_rd_en.
- instr  out  INSTR_W  assembled instruction; byte at pc+k lands in instr[8k+7:8k].
- instr_valid  out  1  instr is stable and offered downstream.
- instr_ready  in  1  downstream accepts instr.
- pc  out  ADDR_W  address of the instruction being fetched or offered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.

## Operation
- FSM states: IDLE, FETCH, DRAIN, OFFER, FINISH.
- IDLE:
  - On start, latch base_addr into pc, latch num_instr, and clear the issued, received and accepted counters.
  - If num_instr==0, go to FINISH; else go to FETCH.
- FETCH:
  - Eight cycles with mem_rd_en=1 and mem_addr=pc+issue_cnt, issue_cnt 0..7.
  - Then go to DRAIN.
- Byte capture:
  - A MEM_LAT-deep valid pipe tags returning bytes.
  - Each tagged byte is written into byte lane rx_cnt, and rx_cnt increments.
  - Capture runs during FETCH and DRAIN.
- DRAIN: wait until rx_cnt==8, then go to OFFER.
- OFFER:
  - instr_valid=1; instr and pc are held constant while instr_ready=0.
  - On instr_valid&&instr_ready: pc←pc+8 (modulo 2^ADDR_W) and accepted_cnt++.
  - If accepted_cnt+1==num_instr, go to FINISH; else go to FETCH.
- FINISH: done=1 for one cycle, then go to IDLE. pc keeps its final value.
- Prefetch: none. The next fetch starts only after the handshake.
- abort:
  - Highest priority after reset; from any state go to IDLE next cycle with instr_valid=0 and no done pulse.
  - Bytes still in flight are discarded: the valid pipe is cleared.
- start while busy is ignored. start and abort in the same cycle in IDLE: abort wins and the FSM stays IDLE.
- Address arithmetic is ADDR_W-bit unsigned with wrap; there is no misalignment check.

## Timing
- Reset values:
  - state=IDLE
  - mem_rd_en=0, mem_addr=0
  - instr=0, instr_valid=0
  - pc=0
  - busy=0, done=0
  - all counters 0
- start at cycle 0 → FETCH at cycle 1 → mem_rd_en high cycles 1–8.
- Last byte is captured at cycle 8+MEM_LAT → instr_valid high from cycle 9+MEM_LAT.
- Fetch latency is 8+MEM_LAT cycles per instruction from FETCH entry.
- Throughput with instr_ready tied high: one instruction per 10+MEM_LAT−1 cycles (FETCH 8, DRAIN MEM_LAT, OFFER 1).
- instr_valid falls the cycle after the handshake and never drops without a handshake, except on abort or rst.
- done pulses the cycle after the final handshake; busy falls with it, together with the return to IDLE.
- num_instr==0: done pulses at cycle 1; no memory reads.
- rst asserted mid-run: all outputs return to their reset values immediately (asynchronous). Later returning mem_rdata is ignored.

## Structure
- Shared package isa_pkg holds:
  - INSTR_W and ADDR_W
  - opcode constants: NOP=5'h00, LOAD_V=5'h01, LOAD_M=5'h02, STORE=5'h03, GEMV=5'h04, RELU=5'h05
  - fetch_state_t enum
- isa_pkg is shared with the decoder.
- One natural sub-module: byte_packer. It holds the MEM_LAT valid pipe plus the 8-lane byte register with rx_cnt and exposes full/clear.
- The FSM and the pc and counters stay in instr_fetch.

## Test plan
- Single instruction: memory at 0x000100 holds bytes 01 28 00 00 00 00 00 12 (byte 0 first); start with base_addr=0x000100, num_instr=1, ready=1.
  - Expected: instr=64'h1200_0000_0000_2801 at cycle 9+MEM_LAT, pc=0x000100, then done one cycle after the handshake.
- Three-instruction run: base 0x0, ready high.
  - Expected: addresses 0x0–0x17 read in order; three valid handshakes with pc 0x0, 0x8, 0x10; done once; final pc=0x18.
- Backpressure: ready held low for 5 cycles during OFFER.
  - Expected: instr, pc and instr_valid stable; no mem_rd_en; fetch resumes the cycle after acceptance.
- num_instr=0.
  - Expected: done at cycle 1; mem_rd_en never asserted.
- PC wrap: base_addr=0xFFFFF8, num_instr=2.
  - Expected: second instruction is read from 0x000000–0x000007, and pc=0x000000 for that offer.
- Abort mid-FETCH and rst during DRAIN with MEM_LAT=3.
  - Expected: return to IDLE; no instr_valid and no done; late mem_rdata ignored; a subsequent start fetches correctly.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the tinyML control path: widths, opcodes and
// the fetch FSM state type used by instr_fetch and the decoder.
package isa_pkg;

    localparam int unsigned INSTR_W = 64;
    localparam int unsigned ADDR_W  = 24;

    localparam logic [4:0] NOP    = 5'h00;
    localparam logic [4:0] LOAD_V = 5'h01;
    localparam logic [4:0] LOAD_M = 5'h02;
    localparam logic [4:0] STORE  = 5'h03;
    localparam logic [4:0] GEMV   = 5'h04;
    localparam logic [4:0] RELU   = 5'h05;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OFFER,
        FINISH
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_byte_packer.sv
// Tags returning memory bytes with a MEM_LAT-deep valid pipe and packs them
// little-endian into an 8-lane instruction register.
module byte_packer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        capture_en,
    input  logic        rd_en,
    input  logic [7:0]  rdata,
    output logic [63:0] data,
    output logic        full,
    output logic        last_byte
);

    logic [MEM_LAT-1:0] vpipe;
    logic [3:0]         rx_cnt;
    logic [7:0][7:0]    lanes;
    logic               tag;

    assign tag       = vpipe[MEM_LAT-1];
    assign full      = (rx_cnt == 4'd8);
    // Lets the FSM leave DRAIN in the same cycle the eighth byte lands.
    assign last_byte = tag && capture_en && (rx_cnt == 4'd7);
    assign data      = lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe  <= '0;
            rx_cnt <= '0;
            lanes  <= '0;
        end else if (clear) begin
            vpipe  <= '0;
            rx_cnt <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            if (tag && capture_en && !full) begin
                lanes[rx_cnt[2:0]] <= rdata;
                rx_cnt             <= rx_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 8 bytes per instruction, offers the assembled
// word over valid/ready and advances pc until num_instr have been accepted.
module instr_fetch #(
    parameter int unsigned ADDR_W  = isa_pkg::ADDR_W,
    parameter int unsigned INSTR_W = isa_pkg::INSTR_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [15:0]        num_instr,
    input  logic               abort,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    import isa_pkg::*;

    fetch_state_t state, state_nx;
    logic [2:0]   issue_cnt;
    logic [15:0]  acc_cnt;
    logic [15:0]  num_lat;
    logic         pk_clear;
    logic         capture_en;
    logic         pk_full;
    logic         pk_last;
    logic [63:0]  pk_data;

    byte_packer #(.MEM_LAT(MEM_LAT)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .capture_en (capture_en),
        .rd_en      (mem_rd_en),
        .rdata      (mem_rdata),
        .data       (pk_data),
        .full       (pk_full),
        .last_byte  (pk_last)
    );

    assign instr = pk_data;

    always_comb begin
        state_nx    = state;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        pk_clear    = 1'b0;
        capture_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pk_clear = 1'b1;
                    state_nx = (num_instr == 16'd0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr   = pc + ADDR_W'(issue_cnt);
                capture_en = 1'b1;
                if (issue_cnt == 3'd7) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                capture_en = 1'b1;
                if (pk_full || pk_last) begin
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pk_clear = 1'b1;
                    state_nx = ((acc_cnt + 16'd1) == num_lat) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort also flushes bytes still in flight from memory.
        if (abort) begin
            state_nx = IDLE;
            pk_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            num_lat   <= '0;
        end else begin
            state <= state_nx;
            if (abort || state != FETCH) begin
                issue_cnt <= '0;
            end else begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (!abort) begin
                if (state == IDLE && start) begin
                    pc      <= base_addr;
                    num_lat <= num_instr;
                    acc_cnt <= '0;
                end else if (state == OFFER && instr_ready) begin
                    pc      <= pc + ADDR_W'(8);
                    acc_cnt <= acc_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: byte-memory model with MEM_LAT latency,
// table-driven program runs, randomized runs, and abort/reset corner sequences.
module tb_instr_fetch;

    localparam int unsigned LAT = 3;
    localparam int          PER = 9 + LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] num_instr;
    logic        abort;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [63:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.ADDR_W(24), .INSTR_W(64), .MEM_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_instr   (num_instr),
        .abort       (abort),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (a >= 24'h000100 && a <= 24'h000107) begin
            case (a[2:0])
                3'd0:    return 8'h01;
                3'd1:    return 8'h28;
                3'd7:    return 8'h12;
                default: return 8'h00;
            endcase
        end
        return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] model_instr(input logic [23:0] a);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = byte_at(a + 24'(j));
        return r;
    endfunction

    // Instruction memory: data returns LAT cycles after the read strobe.
    logic [23:0] apipe [LAT];
    logic        vp    [LAT];
    always @(posedge clk) begin
        apipe[0] <= mem_addr;
        vp[0]    <= mem_rd_en;
        for (int i = 1; i < LAT; i++) begin
            apipe[i] <= apipe[i-1];
            vp[i]    <= vp[i-1];
        end
    end
    assign mem_rdata = vp[LAT-1] ? byte_at(apipe[LAT-1]) : 8'hEE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low for 5 offered cycles
    task automatic run(input logic [23:0] b, input int n, input int rmode,
                       input logic [23:0] exp_pc, input logic has_i0, input logic [63:0] exp_i0);
        logic [23:0] raddr [$];
        logic [23:0] opc [$];
        logic [63:0] oinstr [$];
        int          ocyc [$];
        int          cyc = 0;
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          viol = 0;
        int          stall = 5;
        int          bad = 0;
        logic        prev_stall = 1'b0;
        logic        expect_rd = 1'b0;
        logic        fin = 1'b0;
        logic [63:0] p_instr = '0;
        logic [23:0] p_pc = '0;

        @(negedge clk);
        base_addr = b;
        num_instr = 16'(n);
        start     = 1'b1;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 3 && n > 0) begin
                start     = 1'b1;
                base_addr = ~b;
                num_instr = 16'd7;
            end
            if (cyc == 4) start = 1'b0;
            case (rmode)
                0: instr_ready = 1'b1;
                1: instr_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (instr_valid && stall > 0) begin
                        instr_ready = 1'b0;
                        stall--;
                    end else begin
                        instr_ready = 1'b1;
                    end
                end
            endcase
            if (done_cyc >= 0) begin
                chk("busy_after_done", {63'd0, busy}, 64'd0);
                fin = 1'b1;
            end else begin
                if (expect_rd && !mem_rd_en) viol++;
                expect_rd = 1'b0;
                if (mem_rd_en) raddr.push_back(mem_addr);
                if (mem_rd_en && instr_valid) viol++;
                if (prev_stall && !(instr_valid && instr == p_instr && pc == p_pc)) viol++;
                prev_stall = instr_valid && !instr_ready;
                p_instr    = instr;
                p_pc       = pc;
                if (instr_valid && instr_ready) begin
                    opc.push_back(pc);
                    oinstr.push_back(instr);
                    ocyc.push_back(cyc);
                    expect_rd = (opc.size() < n);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end

        chk("done_count", 64'(done_cnt), 64'd1);
        chk("protocol", 64'(viol), 64'd0);
        chk("read_count", 64'(raddr.size()), 64'(8 * n));
        for (int k = 0; k < raddr.size() && k < 8 * n; k++) begin
            if (raddr[k] !== b + 24'(k)) bad++;
        end
        chk("read_addr", 64'(bad), 64'd0);
        chk("offer_count", 64'(opc.size()), 64'(n));
        for (int k = 0; k < opc.size() && k < n; k++) begin
            chk("offer_pc", {40'd0, opc[k]}, {40'd0, b + 24'(8 * k)});
            chk("offer_instr", oinstr[k], model_instr(b + 24'(8 * k)));
            if (rmode == 0) chk("offer_cycle", 64'(ocyc[k]), 64'((k + 1) * PER));
        end
        if (rmode == 0) chk("done_cycle", 64'(done_cyc), 64'((n == 0) ? 1 : n * PER + 1));
        if (has_i0 && oinstr.size() > 0) chk("instr0", oinstr[0], exp_i0);
        chk("final_pc", {40'd0, pc}, {40'd0, exp_pc});
    endtask

    typedef struct {
        logic [23:0] base;
        int          n;
        int          rmode;
        logic [23:0] exp_pc;
        logic        has_i0;
        logic [63:0] exp_i0;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int d;
        logic [23:0] rb;
        int rn;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        base_addr   = '0;
        num_instr   = '0;
        instr_ready = 1'b0;

        vecs[0] = '{24'h000100, 1, 0, 24'h000108, 1'b1, 64'h1200_0000_0000_2801};
        vecs[1] = '{24'h000000, 3, 0, 24'h000018, 1'b0, 64'd0};
        vecs[2] = '{24'h000040, 0, 0, 24'h000040, 1'b0, 64'd0};
        vecs[3] = '{24'hFFFFF8, 2, 0, 24'h000008, 1'b0, 64'd0};
        vecs[4] = '{24'h000100, 2, 2, 24'h000110, 1'b1, 64'h1200_0000_0000_2801};
        vecs[5] = '{24'h123450, 4, 1, 24'h123470, 1'b0, 64'd0};

        repeat (3) @(negedge clk);
        chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("rst_addr", {40'd0, mem_addr}, 64'd0);
        chk("rst_instr", instr, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_pc", {40'd0, pc}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].base, vecs[i].n, vecs[i].rmode, vecs[i].exp_pc, vecs[i].has_i0, vecs[i].exp_i0);
        end

        for (int r = 0; r < 6; r++) begin
            rb = 24'($urandom);
            rn = int'($urandom_range(1, 3));
            run(rb, rn, 1, rb + 24'(8 * rn), 1'b0, 64'd0);
        end

        // start and abort together in IDLE: stays idle
        @(negedge clk);
        base_addr = 24'h000500;
        num_instr = 16'd1;
        start     = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {63'd0, busy}, 64'd0);
        chk("start_abort_rd", {63'd0, mem_rd_en}, 64'd0);
        @(negedge clk);
        chk("start_abort_busy2", {63'd0, busy}, 64'd0);

        // abort in the middle of FETCH
        @(negedge clk);
        base_addr   = 24'h000200;
        num_instr   = 16'd2;
        start       = 1'b1;
        instr_ready = 1'b1;
        v = 0;
        d = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4) abort = 1'b1;
            if (c == 5) begin
                abort = 1'b0;
                chk("abort_busy", {63'd0, busy}, 64'd0);
                chk("abort_rd", {63'd0, mem_rd_en}, 64'd0);
            end
            if (instr_valid) v++;
            if (done) d++;
        end
        chk("abort_valid", 64'(v), 64'd0);
        chk("abort_done", 64'(d), 64'd0);
        run(24'h000300, 1, 0, 24'h000308, 1'b0, 64'd0);

        // asynchronous reset while draining
        @(negedge clk);
        base_addr = 24'h000400;
        num_instr = 16'd1;
        start     = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("drain_busy", {63'd0, busy}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("mid_rst_addr", {40'd0, mem_addr}, 64'd0);
        chk("mid_rst_instr", instr, 64'd0);
        chk("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("mid_rst_pc", {40'd0, pc}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        v = 0;
        d = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (instr_valid) v++;
            if (done) d++;
        end
        chk("rst_late_valid", 64'(v), 64'd0);
        chk("rst_late_done", 64'(d), 64'd0);
        chk("rst_late_instr", instr, 64'd0);
        run(24'h000400, 1, 0, 24'h000408, 1'b0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
